bp_cfg_loader: RTL and testbench



---
 rtl/bp_cfg_link_pkg.sv | 37 +++
 rtl/bp_cfg_loader_hold.sv | 31 +++
 rtl/bp_cfg_loader.sv | 155 +++++++++++++++
 tb/tb_bp_cfg_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cfg_link_pkg.sv
// Shared cfg-link definitions: register map, loader state encoding and the
// write payload carried from the loader FSM to the output hold stage.
package bp_cfg_link_pkg;

   localparam int CFG_CORE_WIDTH = 8;
   localparam int CFG_ADDR_WIDTH = 16;
   localparam int CFG_DATA_WIDTH = 32;

   localparam logic [CFG_ADDR_WIDTH-1:0] FREEZE     = 16'h0000;
   localparam logic [CFG_ADDR_WIDTH-1:0] CORE_ID    = 16'h0001;
   localparam logic [CFG_ADDR_WIDTH-1:0] CCE_MODE   = 16'h0002;
   localparam logic [CFG_ADDR_WIDTH-1:0] UCODE_BASE = 16'h8000;

   typedef enum logic [3:0] {
      e_idle,
      e_freeze,
      e_core_id,
      e_cce_mode,
      e_ucode_rd,
      e_ucode_wr,
      e_next_core,
      e_unfreeze,
      e_done
   } loader_state_e;

   typedef struct packed {
      logic [CFG_CORE_WIDTH-1:0] core;
      logic [CFG_ADDR_WIDTH-1:0] addr;
      logic [CFG_DATA_WIDTH-1:0] data;
   } cfg_wr_s;

   // Counter width that stays at least one bit for degenerate counts.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bp_cfg_loader_hold.sv
// Keeps the cfg payload stable while the link stalls; a write offered in its
// first cycle passes straight through, later cycles replay the captured copy.
module bp_cfg_loader_hold
   import bp_cfg_link_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  logic    i_v,
   input  cfg_wr_s i_wr,
   input  logic    i_ready,
   output logic    o_v,
   output cfg_wr_s o_wr
);

   logic    r_held_v;
   cfg_wr_s r_wr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_held_v <= 1'b0;
      else          r_held_v <= i_v & ~i_ready;
   end

   // NOTE: the payload copy has no reset; it is only visible while r_held_v is set.
   always_ff @(posedge i_clk) begin
      if (i_v && !i_ready && !r_held_v) r_wr <= i_wr;
   end

   assign o_v  = i_v;
   assign o_wr = r_held_v ? r_wr : i_wr;

endmodule

// File: rtl/bp_cfg_loader.sv
// Post-reset cfg sequencer: freezes each core, writes core id, CCE mode and
// CCE microcode over the cfg link, then unfreezes all cores.
module bp_cfg_loader
   import bp_cfg_link_pkg::*;
#(
   parameter int num_core_p              = 1,
   parameter int cfg_core_width_p        = 8,
   parameter int cfg_addr_width_p        = 16,
   parameter int cfg_data_width_p        = 32,
   parameter int num_cce_instr_ram_els_p = 256
) (
   input  logic                                          clk_i,
   input  logic                                          reset_n_i,
   input  logic                                          start_i,
   input  logic                                          cce_mode_i,
   output logic                                          ucode_v_o,
   output logic [safe_clog2(num_cce_instr_ram_els_p)-1:0] ucode_addr_o,
   input  logic [cfg_data_width_p-1:0]                   ucode_data_i,
   output logic                                          cfg_v_o,
   output logic [cfg_core_width_p-1:0]                   cfg_core_o,
   output logic [cfg_addr_width_p-1:0]                   cfg_addr_o,
   output logic [cfg_data_width_p-1:0]                   cfg_data_o,
   input  logic                                          cfg_ready_i,
   output logic                                          busy_o,
   output logic                                          done_o
);

   localparam int CORE_CNT_W  = safe_clog2(num_core_p);
   localparam int INSTR_CNT_W = safe_clog2(num_cce_instr_ram_els_p);

   if (cfg_core_width_p != CFG_CORE_WIDTH || cfg_addr_width_p != CFG_ADDR_WIDTH ||
       cfg_data_width_p != CFG_DATA_WIDTH) begin : g_bad_link_width
      $error("bp_cfg_loader: cfg link widths differ from bp_cfg_link_pkg");
   end
   if (num_cce_instr_ram_els_p > 0 &&
       (longint'(UCODE_BASE) + longint'(num_cce_instr_ram_els_p) - 1) >=
       (longint'(1) << cfg_addr_width_p)) begin : g_bad_ucode_range
      $error("bp_cfg_loader: UCODE_BASE + instr index overflows cfg address");
   end
   if (num_core_p < 1 || longint'(num_core_p) > (longint'(1) << cfg_core_width_p)) begin : g_bad_core_count
      $error("bp_cfg_loader: num_core_p does not fit the cfg core field");
   end

   loader_state_e           r_state, w_state_nxt;
   logic [CORE_CNT_W-1:0]   r_core_cnt, w_core_cnt_nxt;
   logic [INSTR_CNT_W-1:0]  r_instr_cnt, w_instr_cnt_nxt;
   logic                    w_req_v, w_ucode_v, w_out_v;
   cfg_wr_s                 w_req, w_out;
   logic                    w_last_core, w_last_instr;
   logic [CFG_CORE_WIDTH-1:0] w_core_id;

   assign w_last_core  = (r_core_cnt == CORE_CNT_W'(num_core_p - 1));
   assign w_last_instr = (r_instr_cnt == INSTR_CNT_W'(num_cce_instr_ram_els_p - 1));
   assign w_core_id    = CFG_CORE_WIDTH'(r_core_cnt);

   // NOTE: state registers update with non-blocking assignments only.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= e_idle;
         r_core_cnt  <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_core_cnt  <= w_core_cnt_nxt;
         r_instr_cnt <= w_instr_cnt_nxt;
      end
   end

   // NOTE: every signal of this block is defaulted first so no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_core_cnt_nxt  = r_core_cnt;
      w_instr_cnt_nxt = r_instr_cnt;
      w_req_v         = 1'b0;
      w_req           = '0;
      w_ucode_v       = 1'b0;
      case (r_state)
         e_idle: if (start_i) w_state_nxt = e_freeze;
         e_freeze: begin
            w_req_v = 1'b1;
            w_req   = '{core: w_core_id, addr: FREEZE, data: CFG_DATA_WIDTH'(1)};
            if (cfg_ready_i) w_state_nxt = e_core_id;
         end
         e_core_id: begin
            w_req_v = 1'b1;
            w_req   = '{core: w_core_id, addr: CORE_ID, data: CFG_DATA_WIDTH'(r_core_cnt)};
            if (cfg_ready_i) w_state_nxt = e_cce_mode;
         end
         e_cce_mode: begin
            w_req_v = 1'b1;
            w_req   = '{core: w_core_id, addr: CCE_MODE, data: CFG_DATA_WIDTH'(cce_mode_i)};
            if (cfg_ready_i)
               w_state_nxt = (num_cce_instr_ram_els_p == 0) ? e_next_core : e_ucode_rd;
         end
         e_ucode_rd: begin
            w_ucode_v   = 1'b1;
            w_state_nxt = e_ucode_wr;
         end
         e_ucode_wr: begin
            // ROM data is only valid now; the hold stage keeps it across stalls.
            w_req_v = 1'b1;
            w_req   = '{core: w_core_id, addr: UCODE_BASE + CFG_ADDR_WIDTH'(r_instr_cnt),
                        data: ucode_data_i};
            if (cfg_ready_i) begin
               if (w_last_instr) begin
                  w_instr_cnt_nxt = '0;
                  w_state_nxt     = e_next_core;
               end else begin
                  w_instr_cnt_nxt = r_instr_cnt + 1'b1;
                  w_state_nxt     = e_ucode_rd;
               end
            end
         end
         e_next_core: begin
            if (w_last_core) begin
               w_core_cnt_nxt = '0;
               w_state_nxt    = e_unfreeze;
            end else begin
               w_core_cnt_nxt = r_core_cnt + 1'b1;
               w_state_nxt    = e_freeze;
            end
         end
         e_unfreeze: begin
            w_req_v = 1'b1;
            w_req   = '{core: w_core_id, addr: FREEZE, data: '0};
            if (cfg_ready_i) begin
               if (w_last_core) w_state_nxt    = e_done;
               else             w_core_cnt_nxt = r_core_cnt + 1'b1;
            end
         end
         e_done:  ;
         default: w_state_nxt = e_idle;
      endcase
   end

   bp_cfg_loader_hold u_hold (
      .i_clk   (clk_i),
      .i_rst_n (reset_n_i),
      .i_v     (w_req_v),
      .i_wr    (w_req),
      .i_ready (cfg_ready_i),
      .o_v     (w_out_v),
      .o_wr    (w_out)
   );

   assign cfg_v_o      = w_out_v;
   assign cfg_core_o   = w_out.core;
   assign cfg_addr_o   = w_out.addr;
   assign cfg_data_o   = w_out.data;
   assign ucode_v_o    = w_ucode_v;
   assign ucode_addr_o = w_ucode_v ? r_instr_cnt : '0;
   assign busy_o       = (r_state != e_idle) && (r_state != e_done);
   assign done_o       = (r_state == e_done);

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Self-checking bench for bp_cfg_loader: two cores, four microcode words,
// expected write list rebuilt from the register-map rules.
module tb_bp_cfg_loader;

   localparam int N   = 2;
   localparam int ELS = 4;

   typedef struct packed {
      logic [7:0]  core;
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        start_i;
   logic        cce_mode_i;
   logic        ucode_v_o;
   logic [1:0]  ucode_addr_o;
   logic [31:0] ucode_data_i;
   logic        cfg_v_o;
   logic [7:0]  cfg_core_o;
   logic [15:0] cfg_addr_o;
   logic [31:0] cfg_data_o;
   logic        cfg_ready_i;
   logic        busy_o;
   logic        done_o;

   bp_cfg_loader #(
      .num_core_p              (N),
      .cfg_core_width_p        (8),
      .cfg_addr_width_p        (16),
      .cfg_data_width_p        (32),
      .num_cce_instr_ram_els_p (ELS)
   ) dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .start_i      (start_i),
      .cce_mode_i   (cce_mode_i),
      .ucode_v_o    (ucode_v_o),
      .ucode_addr_o (ucode_addr_o),
      .ucode_data_i (ucode_data_i),
      .cfg_v_o      (cfg_v_o),
      .cfg_core_o   (cfg_core_o),
      .cfg_addr_o   (cfg_addr_o),
      .cfg_data_o   (cfg_data_o),
      .cfg_ready_i  (cfg_ready_i),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] rom [ELS];
   wr_t exp_q [$];
   wr_t got_q [$];
   int  ucode_pulses, max_ucode_addr, stall_errs;
   logic prev_stall = 1'b0;
   wr_t  prev_wr, cur_wr;

   // ROM: data valid exactly one cycle after the read strobe, junk otherwise.
   always @(posedge clk_i) ucode_data_i <= ucode_v_o ? rom[ucode_addr_o] : $urandom;

   always @(negedge clk_i) begin
      if (!reset_n_i) prev_stall = 1'b0;
      else begin
         cur_wr = {cfg_core_o, cfg_addr_o, cfg_data_o};
         if (prev_stall && (!cfg_v_o || cur_wr !== prev_wr)) stall_errs++;
         if (cfg_v_o && cfg_ready_i) got_q.push_back(cur_wr);
         if (ucode_v_o) begin
            ucode_pulses++;
            if (int'(ucode_addr_o) > max_ucode_addr) max_ucode_addr = int'(ucode_addr_o);
         end
         prev_stall = cfg_v_o && !cfg_ready_i;
         prev_wr    = cur_wr;
      end
   end

   function automatic void build_expected(input bit mode);
      exp_q.delete();
      for (int c = 0; c < N; c++) begin
         exp_q.push_back({8'(c), 16'h0000, 32'd1});
         exp_q.push_back({8'(c), 16'h0001, 32'(c)});
         exp_q.push_back({8'(c), 16'h0002, 32'(mode)});
         for (int i = 0; i < ELS; i++) exp_q.push_back({8'(c), 16'(16'h8000 + i), rom[i]});
      end
      for (int c = 0; c < N; c++) exp_q.push_back({8'(c), 16'h0000, 32'd0});
   endfunction

   function automatic int first_diff();
      int n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic apply_reset();
      reset_n_i   = 1'b0;
      start_i     = 1'b0;
      cfg_ready_i = 1'b1;
      cce_mode_i  = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 reset_n_i = 1'b1;
   endtask

   task automatic start_seq();
      got_q.delete();
      ucode_pulses = 0; max_ucode_addr = 0; stall_errs = 0;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int ready_pct, input bit poke, output int k_done,
                            output bit timed_out);
      timed_out = 1'b1; k_done = 0;
      for (int k = 1; k <= 2000; k++) begin
         cfg_ready_i = ($urandom_range(0, 99) < ready_pct);
         start_i     = poke && (k % 3 == 0);
         @(posedge clk_i); #1;
         if (done_o) begin k_done = k; timed_out = 1'b0; break; end
      end
      start_i = 1'b0; cfg_ready_i = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      @(posedge clk_i); #1;
      n_tests++; if (cfg_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_v got %b exp 0", cfg_v_o); end
      n_tests++; if (ucode_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_ucode_v got %b exp 0", ucode_v_o); end
      n_tests++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL reset_status got busy=%b done=%b exp 0/0", busy_o, done_o); end
      n_tests++; if ({cfg_core_o, cfg_addr_o, cfg_data_o, ucode_addr_o} !== '0) begin n_fail++; $display("FAIL reset_payload got %h/%h/%h addr=%h exp 0", cfg_core_o, cfg_addr_o, cfg_data_o, ucode_addr_o); end
   endtask

   task automatic test_basic();
      int k, d; bit to;
      apply_reset();
      for (int i = 0; i < ELS; i++) rom[i] = 32'hA0 + i;
      build_expected(1'b0);
      start_seq();
      wait_done(100, 1'b0, k, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout done_o never rose"); end
      n_tests++; if (k != N * (3 + 2 * ELS + 1) + N) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", k, N * (3 + 2 * ELS + 1) + N); end
      n_tests++; if (got_q.size() != N * (3 + ELS) + N) begin n_fail++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), N * (3 + ELS) + N); end
      d = first_diff();
      n_tests++; if (d != -1) begin n_fail++; $display("FAIL basic_order idx %0d got %h exp %h", d, got_q[d], exp_q[d]); end
      n_tests++; if (ucode_pulses != N * ELS) begin n_fail++; $display("FAIL basic_ucode_reads got %0d exp %0d", ucode_pulses, N * ELS); end
      n_tests++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin n_fail++; $display("FAIL basic_final got busy=%b done=%b exp 0/1", busy_o, done_o); end
   endtask

   task automatic test_stall();
      int k, d, pulses_before; bit to, found;
      apply_reset();
      build_expected(1'b0);
      start_seq();
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (cfg_v_o && cfg_addr_o == 16'h8001) begin found = 1'b1; break; end
         @(posedge clk_i); #1;
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL stall_reach ucode write 8001 not seen"); end
      if (found) begin
         cfg_ready_i   = 1'b0;
         pulses_before = ucode_pulses;
         repeat (5) @(posedge clk_i);
         #1;
         n_tests++; if ({cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o} !== {1'b1, 8'd0, 16'h8001, rom[1]}) begin n_fail++; $display("FAIL stall_payload got v=%b %h/%h/%h exp 1 00/8001/%h", cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, rom[1]); end
         n_tests++; if (ucode_pulses != pulses_before) begin n_fail++; $display("FAIL stall_extra_read got %0d exp %0d", ucode_pulses, pulses_before); end
         cfg_ready_i = 1'b1;
      end
      wait_done(100, 1'b0, k, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL stall_timeout done_o never rose"); end
      d = first_diff();
      n_tests++; if (d != -1) begin n_fail++; $display("FAIL stall_order idx %0d got %h exp %h", d, got_q[d], exp_q[d]); end
      n_tests++; if (stall_errs != 0) begin n_fail++; $display("FAIL stall_stable got %0d unstable cycles exp 0", stall_errs); end
   endtask

   task automatic test_reset_mid();
      int k, d; bit to, found;
      apply_reset();
      build_expected(1'b0);
      start_seq();
      found = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (cfg_v_o && cfg_core_o == 8'd1 && cfg_addr_o[15]) begin found = 1'b1; break; end
         @(posedge clk_i); #1;
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL abort_reach core 1 ucode write not seen"); end
      reset_n_i = 1'b0;
      #1;
      n_tests++; if ({cfg_v_o, ucode_v_o, busy_o, done_o} !== 4'b0) begin n_fail++; $display("FAIL abort_status got v=%b uv=%b busy=%b done=%b exp 0", cfg_v_o, ucode_v_o, busy_o, done_o); end
      n_tests++; if ({cfg_core_o, cfg_addr_o, cfg_data_o} !== '0) begin n_fail++; $display("FAIL abort_payload got %h/%h/%h exp 0", cfg_core_o, cfg_addr_o, cfg_data_o); end
      @(posedge clk_i); #1;
      reset_n_i = 1'b1;
      @(posedge clk_i); #1;
      start_seq();
      wait_done(100, 1'b0, k, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL abort_timeout done_o never rose"); end
      n_tests++; if (got_q.size() == 0 || got_q[0] !== {8'd0, 16'h0000, 32'd1}) begin n_fail++; $display("FAIL abort_restart first write got %h exp 00_0000_00000001", (got_q.size() != 0) ? got_q[0] : '0); end
      d = first_diff();
      n_tests++; if (d != -1) begin n_fail++; $display("FAIL abort_order idx %0d got %h exp %h", d, got_q[d], exp_q[d]); end
   endtask

   task automatic test_start_ignored();
      int k, d; bit to;
      apply_reset();
      build_expected(1'b0);
      start_seq();
      wait_done(100, 1'b1, k, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL restart_timeout done_o never rose"); end
      d = first_diff();
      n_tests++; if (d != -1) begin n_fail++; $display("FAIL restart_busy_order idx %0d got %h exp %h", d, got_q[d], exp_q[d]); end
      start_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL restart_done_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      n_tests++; if ({done_o, busy_o, cfg_v_o, ucode_v_o} !== 4'b1000) begin n_fail++; $display("FAIL restart_done_state got done=%b busy=%b v=%b uv=%b exp 1/0/0/0", done_o, busy_o, cfg_v_o, ucode_v_o); end
   endtask

   task automatic test_random();
      int k, d; bit to;
      for (int it = 0; it < 3; it++) begin
         apply_reset();
         for (int i = 0; i < ELS; i++) rom[i] = $urandom;
         cce_mode_i = 1'b1;
         build_expected(1'b1);
         start_seq();
         wait_done(50, 1'b0, k, to);
         n_tests++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout done_o never rose", it); end
         d = first_diff();
         n_tests++; if (d != -1) begin n_fail++; $display("FAIL rand%0d_order idx %0d got %h exp %h", it, d, got_q[d], exp_q[d]); end
         n_tests++; if (stall_errs != 0) begin n_fail++; $display("FAIL rand%0d_stable got %0d exp 0", it, stall_errs); end
         n_tests++; if (max_ucode_addr > ELS - 1 || ucode_pulses != N * ELS) begin n_fail++; $display("FAIL rand%0d_ucode got max=%0d reads=%0d exp max<=%0d reads=%0d", it, max_ucode_addr, ucode_pulses, ELS - 1, N * ELS); end
      end
   endtask

   initial begin
      reset_n_i   = 1'b0;
      start_i     = 1'b0;
      cce_mode_i  = 1'b0;
      cfg_ready_i = 1'b1;
      for (int i = 0; i < ELS; i++) rom[i] = 32'hA0 + i;
      test_reset();
      test_basic();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
